time_set_controller: RTL and testbench
======================================

// Module: time_set_controller
// PURPOSE
//   Consumes the 2-bit press code from the button state detector and keeps an HH:MM:SS time-of-day.
//   The time runs from an internal 1 Hz tick.
//   A long press steps through the edit fields; a short press or auto-repeat increments the selected field.
//   Outputs feed the display/BCD stage directly downstream.
// PARAMETERS
//   FREQ_CLK  30'd50_000_000  clk frequency in Hz; sets the 1 Hz tick and the blink rate
// PORTS
//   clk         in   1  system clock; all logic on posedge
//   reset       in   1  synchronous, active-high reset
//   btn_state   in   2  press code: 0 none, 1 short/repeat, 2 long, 3 reserved (= none); one-cycle pulse
//   hours       out  5  0..23
//   minutes     out  6  0..59
//   seconds     out  6  0..59
//   edit_field  out  2  0 RUN, 1 HOUR, 2 MIN, 3 SEC (current FSM state)
//   blink       out  1  2 Hz square wave while editing; 0 in RUN
// BEHAVIOUR
// - Reset (reset=1 at posedge):
//   - hours/minutes/seconds = 0; edit_field = RUN; blink = 0
//   - tick counter = 0; blink counter = 0
// - All outputs registered. A btn_state event sampled at edge N is visible after edge N.
// - FSM transitions on btn_state==2: RUN->HOUR->MIN->SEC->RUN. Other codes never change the state.
// - btn_state==1 in HOUR/MIN/SEC: +1 to the selected field, with wrap:
//   - hours 23->0; minutes/seconds 59->0
//   - no carry into other fields while editing
// - btn_state==1 in RUN: ignored.
// - btn_state==3: ignored in every state.
// - 1 Hz tick: 30-bit counter runs only in RUN.
//   - At FREQ_CLK-1 the counter clears and seconds increments.
//   - Carry rules: seconds 59->0 carries into minutes; minutes 59->0 carries into hours; 23:59:59 -> 00:00:00.
// - Time is frozen in any edit state; the tick counter is held at 0.
// - On SEC->RUN the tick counter starts from 0: first increment exactly FREQ_CLK cycles after the return edge.
// - Simultaneous events in RUN: btn_state==2 in the same cycle as a tick -> enter HOUR, tick discarded, seconds unchanged.
// - blink:
//   - Counter toggles blink every FREQ_CLK/4 cycles while edit_field != RUN.
//   - On entering HOUR from RUN, blink = 1 and the counter = 0.
//   - On return to RUN, blink = 0 and the counter = 0.
// - Mid-operation reset:
//   - reset overrides all events in that cycle, including btn_state and tick.
//   - From any state, the next state is RUN with 00:00:00.
// - Width rules: comparisons use full 30-bit FREQ_CLK; FREQ_CLK/4 truncates. FREQ_CLK >= 4 is required.
// TESTING (bench uses FREQ_CLK=8)
//   1. reset 2 cycles -> 00:00:00, edit_field=0, blink=0; 8 idle cycles -> seconds=1 on 8th edge after release
//   2. Run from 23:59:58 for 16 cycles -> 23:59:59 then 00:00:00
//   3. Pulse code 2 -> edit_field=1, blink=1; 24 pulses of code 1 -> hours 0..23 then 0, no tick advance
//   4. In MIN at 59, code 1 -> minutes=0, hours unchanged
//      In SEC at 59, code 1 -> seconds=0, minutes unchanged
//   5. Tick edge coincident with code 2 in RUN at 00:00:05 -> edit_field=1, seconds stays 5
//      Code 3 in any state -> no change
//   6. In MIN at 12:34:56, assert reset -> next edge 00:00:00, RUN, blink=0
//      Four code-2 pulses -> states 1,2,3,0; time resumes 8 cycles after the last pulse

Source files
------------

// File: rtl/time_set_controller_if.sv
// Press-code input and time/edit-status outputs of the time-set controller.
// The slave side is the controller; the master side drives the press codes.
interface time_set_controller_if;
  logic [1:0] btn_state;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic [1:0] edit_field;
  logic       blink;

  modport master (
    output btn_state,
    input  hours,
    input  minutes,
    input  seconds,
    input  edit_field,
    input  blink
  );

  modport slave (
    input  btn_state,
    output hours,
    output minutes,
    output seconds,
    output edit_field,
    output blink
  );
endinterface

// File: rtl/time_set_controller.sv
// HH:MM:SS time-of-day with a 1 Hz tick and button-driven field editing.
// Long press cycles RUN->HOUR->MIN->SEC->RUN; short press bumps the selected field.
module time_set_controller #(
  parameter logic [29:0] FREQ_CLK = 30'd50_000_000
) (
  input logic                      clk,
  input logic                      reset,
  time_set_controller_if.slave     bus
);

  localparam logic [29:0] TickLast  = FREQ_CLK - 30'd1;
  localparam logic [29:0] BlinkLast = (FREQ_CLK >> 2) - 30'd1;

  typedef enum logic [1:0] {
    StRun  = 2'd0,
    StHour = 2'd1,
    StMin  = 2'd2,
    StSec  = 2'd3
  } state_e;

  state_e      r_state;
  logic [4:0]  r_hours;
  logic [5:0]  r_minutes;
  logic [5:0]  r_seconds;
  logic        r_blink;
  logic [29:0] r_tick_cnt;
  logic [29:0] r_blink_cnt;

  logic        w_long;
  logic        w_short;
  logic        w_tick;
  logic        w_blink_hit;
  logic        w_sec_max;
  logic        w_min_max;
  logic        w_hour_max;

  assign w_long      = (bus.btn_state == 2'd2);
  assign w_short     = (bus.btn_state == 2'd1);
  assign w_tick      = (r_tick_cnt == TickLast);
  assign w_blink_hit = (r_blink_cnt == BlinkLast);
  assign w_sec_max   = (r_seconds == 6'd59);
  assign w_min_max   = (r_minutes == 6'd59);
  assign w_hour_max  = (r_hours == 5'd23);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StRun;
      r_hours     <= '0;
      r_minutes   <= '0;
      r_seconds   <= '0;
      r_blink     <= 1'b0;
      r_tick_cnt  <= '0;
      r_blink_cnt <= '0;
    end else begin
      unique case (r_state)
        StRun: begin
          r_blink_cnt <= '0;
          r_blink     <= 1'b0;
          if (w_long) begin
            // A long press wins over a coincident tick; that tick is dropped.
            r_state    <= StHour;
            r_tick_cnt <= '0;
            r_blink    <= 1'b1;
          end else if (w_tick) begin
            r_tick_cnt <= '0;
            r_seconds  <= w_sec_max ? 6'd0 : r_seconds + 6'd1;
            if (w_sec_max) begin
              r_minutes <= w_min_max ? 6'd0 : r_minutes + 6'd1;
              if (w_min_max) begin
                r_hours <= w_hour_max ? 5'd0 : r_hours + 5'd1;
              end
            end
          end else begin
            r_tick_cnt <= r_tick_cnt + 30'd1;
          end
        end

        StHour, StMin, StSec: begin
          r_tick_cnt <= '0;
          if (w_long && (r_state == StSec)) begin
            r_state     <= StRun;
            r_blink     <= 1'b0;
            r_blink_cnt <= '0;
          end else begin
            if (w_long) begin
              r_state <= (r_state == StHour) ? StMin : StSec;
            end
            if (w_blink_hit) begin
              r_blink     <= ~r_blink;
              r_blink_cnt <= '0;
            end else begin
              r_blink_cnt <= r_blink_cnt + 30'd1;
            end
          end
          // Editing bumps one field only; no carry into neighbours.
          if (w_short) begin
            if (r_state == StHour) begin
              r_hours <= w_hour_max ? 5'd0 : r_hours + 5'd1;
            end else if (r_state == StMin) begin
              r_minutes <= w_min_max ? 6'd0 : r_minutes + 6'd1;
            end else begin
              r_seconds <= w_sec_max ? 6'd0 : r_seconds + 6'd1;
            end
          end
        end

        default: r_state <= StRun;
      endcase
    end
  end

  assign bus.hours      = r_hours;
  assign bus.minutes    = r_minutes;
  assign bus.seconds    = r_seconds;
  assign bus.edit_field = r_state;
  assign bus.blink      = r_blink;

endmodule

// File: tb/tb_time_set_controller.sv
// Directed bench for time_set_controller with FREQ_CLK = 8 (tick every 8 run cycles,
// blink toggling every 2 edit cycles).
module tb_time_set_controller;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  time_set_controller_if tb_if ();

  time_set_controller #(
    .FREQ_CLK (30'd8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (tb_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Apply one press code for exactly one clock edge, then sample 1 ns after that edge.
  task automatic step(input logic [1:0] code);
    tb_if.btn_state = code;
    @(posedge clk);
    #1;
    tb_if.btn_state = 2'd0;
  endtask

  task automatic steps(input logic [1:0] code, input int n);
    for (int k = 0; k < n; k++) step(code);
  endtask

  task automatic check_time(input string tag, input int unsigned h, input int unsigned m,
                            input int unsigned s);
    check_eq({tag, ".hours"}, tb_if.hours, h);
    check_eq({tag, ".minutes"}, tb_if.minutes, m);
    check_eq({tag, ".seconds"}, tb_if.seconds, s);
  endtask

  initial begin
    n_checks        = 0;
    n_fail          = 0;
    reset           = 1'b1;
    tb_if.btn_state = 2'd0;
    #1;

    // 1. Reset, then first tick on the 8th edge after release.
    steps(2'd0, 2);
    reset = 1'b0;
    check_time("reset", 0, 0, 0);
    check_eq("reset.edit_field", tb_if.edit_field, 0);
    check_eq("reset.blink", tb_if.blink, 0);
    steps(2'd0, 7);
    check_eq("pre_tick.seconds", tb_if.seconds, 0);
    step(2'd0);
    check_eq("first_tick.seconds", tb_if.seconds, 1);

    // 3. Enter HOUR and walk hours through a full wrap; blink holds 2 cycles per level.
    step(2'd2);
    check_eq("enter_hour.edit_field", tb_if.edit_field, 1);
    check_eq("enter_hour.blink", tb_if.blink, 1);
    for (int i = 0; i < 24; i++) begin
      step(2'd1);
      check_eq("hour_inc.hours", tb_if.hours, (i + 1) % 24);
      check_eq("hour_inc.blink", tb_if.blink, (((i + 1) / 2) % 2 == 0) ? 1 : 0);
    end
    check_eq("hour_edit.seconds_frozen", tb_if.seconds, 1);
    check_eq("hour_edit.minutes", tb_if.minutes, 0);
    steps(2'd1, 23);
    check_eq("hour_set.hours", tb_if.hours, 23);

    // 4. Minute wrap without carry into hours.
    step(2'd2);
    check_eq("enter_min.edit_field", tb_if.edit_field, 2);
    steps(2'd1, 59);
    check_eq("min_set.minutes", tb_if.minutes, 59);
    step(2'd1);
    check_eq("min_wrap.minutes", tb_if.minutes, 0);
    check_eq("min_wrap.hours", tb_if.hours, 23);
    steps(2'd1, 59);

    // Second wrap without carry into minutes.
    step(2'd2);
    check_eq("enter_sec.edit_field", tb_if.edit_field, 3);
    steps(2'd1, 58);
    check_eq("sec_set.seconds", tb_if.seconds, 59);
    step(2'd1);
    check_eq("sec_wrap.seconds", tb_if.seconds, 0);
    check_eq("sec_wrap.minutes", tb_if.minutes, 59);
    steps(2'd1, 58);

    // 2. Back to RUN at 23:59:58; day rollover after two ticks.
    step(2'd2);
    check_eq("exit_sec.edit_field", tb_if.edit_field, 0);
    check_eq("exit_sec.blink", tb_if.blink, 0);
    check_time("run_start", 23, 59, 58);
    steps(2'd0, 7);
    check_eq("run7.seconds", tb_if.seconds, 58);
    step(2'd0);
    check_time("run8", 23, 59, 59);
    steps(2'd0, 8);
    check_time("rollover", 0, 0, 0);

    // 5. Long press coincident with a tick at 00:00:05: tick discarded.
    steps(2'd0, 47);
    check_time("pre_coincide", 0, 0, 5);
    step(2'd2);
    check_eq("coincide.edit_field", tb_if.edit_field, 1);
    check_eq("coincide.seconds", tb_if.seconds, 5);
    step(2'd3);
    check_eq("code3_hour.edit_field", tb_if.edit_field, 1);
    check_eq("code3_hour.hours", tb_if.hours, 0);
    step(2'd2);
    step(2'd3);
    check_eq("code3_min.edit_field", tb_if.edit_field, 2);
    check_eq("code3_min.minutes", tb_if.minutes, 0);

    // 6. Build 12:34:56 in MIN, checking code 3 and code 1 are ignored in RUN on the way.
    step(2'd2);
    steps(2'd1, 51);
    check_eq("sec56.seconds", tb_if.seconds, 56);
    step(2'd2);
    check_eq("run_again.edit_field", tb_if.edit_field, 0);
    step(2'd3);
    check_eq("code3_run.edit_field", tb_if.edit_field, 0);
    step(2'd1);
    check_time("code1_run", 0, 0, 56);
    step(2'd2);
    steps(2'd1, 12);
    step(2'd2);
    steps(2'd1, 34);
    check_time("preset", 12, 34, 56);
    check_eq("preset.edit_field", tb_if.edit_field, 2);

    // Reset overrides a simultaneous short press.
    reset = 1'b1;
    step(2'd1);
    reset = 1'b0;
    check_time("mid_reset", 0, 0, 0);
    check_eq("mid_reset.edit_field", tb_if.edit_field, 0);
    check_eq("mid_reset.blink", tb_if.blink, 0);

    // Full field cycle, then tick restarts from 0 on the return edge.
    for (int i = 0; i < 4; i++) begin
      step(2'd2);
      check_eq("cycle.edit_field", tb_if.edit_field, (i + 1) % 4);
    end
    steps(2'd0, 7);
    check_eq("resume7.seconds", tb_if.seconds, 0);
    step(2'd0);
    check_eq("resume8.seconds", tb_if.seconds, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
